rxreq_dispatch: RTL and testbench
=================================

Name: rxreq_dispatch

Overview:
- CHI RXREQ link-layer receiver for the HN-F, directly upstream of the POCQ.
- Issues L-credits to the interconnect and accepts request flits into a credit-sized ingress FIFO.
- Dispatches the FIFO head into the POCQ as a one-cycle fill pulse, and only when the POCQ has a free entry.
- Tracks POCQ occupancy, so the POCQ never sees a fill while it is full.

Parameters:
NUM_LCRD, 4, maximum L-credits outstanding to the requester; also the ingress FIFO depth (power of 2, ≥2)
POCQ_DEPTH, 16, number of POCQ entries tracked by the occupancy counter

Ports:
clk  input  1  clock
rst  input  1  reset
rxreqflitv  input  1  incoming flit valid; consumes one L-credit
rxreqflit  input  $bits(reqflit_t)  incoming request flit (reqflit_t)
rxreqlcrdv  output  1  L-credit grant pulse, one credit per asserted cycle
rxreq_pocq_first_entry_dis  output  1  POCQ fill strobe
rxreq_pocq_first_entry  output  $bits(reqflit_t)  flit presented to the POCQ (reqflit_t)
pocq_entry_release  input  1  POCQ retires one entry this cycle
pocq_used  output  $clog2(POCQ_DEPTH+1)  current POCQ occupancy
rxreq_err  output  1  sticky protocol-error flag

Behaviour:
- Reset: clk, rst synchronous, active-high. All state clears: FIFO empty, pointers 0, lcrd_out=0, pocq_used=0, rxreqlcrdv=0, rxreq_err=0. Reset asserted mid-operation discards buffered flits and outstanding credits with no drain.
- Credit counter lcrd_out (0..NUM_LCRD):
  - +1 on each rxreqlcrdv cycle; −1 on each accepted rxreqflitv.
  - Simultaneous grant and flit leaves it unchanged.
- Credit issue:
  - rxreqlcrdv is a registered output.
  - Next value = 1 when lcrd_out_next + fifo_cnt_next + 1 ≤ NUM_LCRD, evaluated on next-state values.
  - Invariant: lcrd_out + fifo_cnt ≤ NUM_LCRD at all times.
  - First grant is possible in the cycle after rst deasserts.
  - Credits stream one per cycle until the budget is exhausted.
- Flit accept:
  - rxreqflitv=1 with lcrd_out=0 is a protocol error: flit dropped, rxreq_err set, never cleared except by rst.
  - Otherwise the flit is pushed to FIFO tail.
  - The FIFO cannot overflow while the invariant holds.
- Dispatch (combinational):
  - rxreq_pocq_first_entry_dis = fifo non-empty AND pocq_used < POCQ_DEPTH.
  - rxreq_pocq_first_entry = FIFO head whenever the FIFO is non-empty; 0 when empty.
  - Dispatch pops the head in the same cycle.
  - Minimum latency: flit at cycle N → dis at cycle N+1 (no bypass).
  - Push and pop in the same cycle are both legal, including with 1 entry.
  - Pointers wrap modulo NUM_LCRD.
  - Order is strict FIFO; at most one dispatch per cycle.
- POCQ occupancy counter pocq_used:
  - +1 on dispatch, −1 on pocq_entry_release; both in the same cycle leaves it unchanged.
  - Release with pocq_used=0 and no dispatch that cycle: ignored and sets rxreq_err.
  - When pocq_used = POCQ_DEPTH, dispatch stalls. Flits then back up in the FIFO, and credit issue stops naturally via the invariant.
- pocq_used is a registered output.

Optional Feature:
- Macro: RXREQ_LCRD_RETURN_FILTER_EN.
- When defined: an accepted flit with opcode == 0x00 (ReqLCrdReturn) is not pushed.
  - It still decrements lcrd_out, so the credit returns to the budget and can be re-granted.
  - It never reaches the POCQ.
- When undefined: every accepted flit is pushed and dispatched regardless of opcode.

Test Plan:
1. Reset release, no traffic → rxreqlcrdv high on cycles 1..4 after reset, then low. lcrd_out=4, no dis, pocq_used=0.
2. Single flit (txnid=0x12) after credits granted → dis pulses exactly one cycle later carrying txnid 0x12. pocq_used=1, one new credit granted the following cycle.
3. Back-to-back flits A, B, C, D → dis on 4 consecutive cycles in order A, B, C, D; pocq_used=4.
4. POCQ full: 16 dispatches with no releases, then 4 more flits.
   - Required: pocq_used=16, dis stays low, FIFO holds 4, rxreqlcrdv stays low.
   - Then one release → exactly one dispatch next cycle.
5. Errors:
   - Flit with lcrd_out=0 → rxreq_err=1, no dispatch, state otherwise unchanged.
   - Release with pocq_used=0 → rxreq_err=1.
6. With RXREQ_LCRD_RETURN_FILTER_EN, send opcode 0x00 → no dis, lcrd_out drops by 1 and is re-granted. Without the macro, the same flit is dispatched.

Source files
------------

// File: rtl/rxreq_dispatch_if.sv
`default_nettype none
//==============================================================================
//  rxreq_dispatch_pkg / rxreq_dispatch_if
//------------------------------------------------------------------------------
//  Request flit type and the bundled RXREQ link + POCQ-fill interface.
//
//  Interface members:
//    rxreqflitv                  flit valid from the interconnect (consumes a credit)
//    rxreqflit                   request flit
//    rxreqlcrdv                  L-credit grant pulse to the interconnect
//    rxreq_pocq_first_entry_dis  POCQ fill strobe
//    rxreq_pocq_first_entry      flit presented to the POCQ
//    pocq_entry_release          POCQ retires one entry
//    pocq_used                   POCQ occupancy
//    rxreq_err                   sticky protocol-error flag
//
//  Modports: slave = the dispatcher, master = interconnect/POCQ side.
//
//  Revision: 1.0 - initial release
//==============================================================================
package rxreq_dispatch_pkg;

   typedef struct packed {
      logic [3:0]  qos;
      logic [6:0]  tgtid;
      logic [6:0]  srcid;
      logic [11:0] txnid;
      logic [6:0]  opcode;
      logic [47:0] addr;
   } reqflit_t;

   // ReqLCrdReturn opcode: a credit handed back by the requester.
   localparam logic [6:0] c_opc_reqlcrdreturn = 7'h00;

endpackage

interface rxreq_dispatch_if #(
   parameter int POCQ_DEPTH = 16
);
   import rxreq_dispatch_pkg::*;

   logic                              rxreqflitv;
   reqflit_t                          rxreqflit;
   logic                              rxreqlcrdv;
   logic                              rxreq_pocq_first_entry_dis;
   reqflit_t                          rxreq_pocq_first_entry;
   logic                              pocq_entry_release;
   logic [$clog2(POCQ_DEPTH+1)-1:0]   pocq_used;
   logic                              rxreq_err;

   modport slave (
      input  rxreqflitv,
      input  rxreqflit,
      input  pocq_entry_release,
      output rxreqlcrdv,
      output rxreq_pocq_first_entry_dis,
      output rxreq_pocq_first_entry,
      output pocq_used,
      output rxreq_err
   );

   modport master (
      output rxreqflitv,
      output rxreqflit,
      output pocq_entry_release,
      input  rxreqlcrdv,
      input  rxreq_pocq_first_entry_dis,
      input  rxreq_pocq_first_entry,
      input  pocq_used,
      input  rxreq_err
   );

endinterface
`default_nettype wire

// File: rtl/rxreq_dispatch.sv
`default_nettype none
//==============================================================================
//  rxreq_dispatch
//------------------------------------------------------------------------------
//  CHI RXREQ link-layer receiver for the HN-F. Grants L-credits, buffers
//  incoming request flits in a credit-sized FIFO and fills the POCQ from the
//  FIFO head whenever the POCQ has a free entry, tracking POCQ occupancy.
//
//  Ports:
//    clk   clock
//    rst   synchronous active-high reset
//    bus   rxreq_dispatch_if.slave (flit link, credit grant, POCQ fill/release,
//          occupancy, error flag)
//
//  Parameters:
//    NUM_LCRD    max outstanding L-credits and FIFO depth (power of 2, >= 2)
//    POCQ_DEPTH  POCQ entries tracked by the occupancy counter
//
//  Build option:
//    RXREQ_LCRD_RETURN_FILTER_EN - accepted ReqLCrdReturn flits (opcode 0x00)
//    release their credit but are not buffered or dispatched.
//
//  Revision: 1.0 - initial release
//==============================================================================
module rxreq_dispatch
   import rxreq_dispatch_pkg::*;
#(
   parameter int NUM_LCRD   = 4,
   parameter int POCQ_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   rxreq_dispatch_if.slave  bus
);

   localparam int c_ptr_w  = $clog2(NUM_LCRD);
   localparam int c_cnt_w  = $clog2(NUM_LCRD + 1);
   localparam int c_sum_w  = c_cnt_w + 1;
   localparam int c_used_w = $clog2(POCQ_DEPTH + 1);

   localparam logic [c_sum_w-1:0]  c_budget    = c_sum_w'(NUM_LCRD);
   localparam logic [c_used_w-1:0] c_pocq_full = c_used_w'(POCQ_DEPTH);

   reqflit_t               mem_q [NUM_LCRD];
   reqflit_t               mem_d [NUM_LCRD];
   logic [c_ptr_w-1:0]     wr_ptr_q,    wr_ptr_d;
   logic [c_ptr_w-1:0]     rd_ptr_q,    rd_ptr_d;
   logic [c_cnt_w-1:0]     fifo_cnt_q,  fifo_cnt_d;
   logic [c_cnt_w-1:0]     lcrd_out_q,  lcrd_out_d;
   logic                   lcrdv_q,     lcrdv_d;
   logic [c_used_w-1:0]    pocq_used_q, pocq_used_d;
   logic                   err_q,       err_d;

   logic                   w_fifo_nempty;
   logic                   w_dis;
   logic                   w_accept;
   logic                   w_push;
   logic                   w_drop_err;
   logic                   w_rel_err;
   logic [c_sum_w-1:0]     w_budget_need;

   always_comb begin
      w_fifo_nempty = (fifo_cnt_q != '0);
      w_dis         = w_fifo_nempty && (pocq_used_q < c_pocq_full);

      // A flit arriving with no credit outstanding is dropped and flagged.
      w_drop_err    = bus.rxreqflitv && (lcrd_out_q == '0);
      w_accept      = bus.rxreqflitv && (lcrd_out_q != '0);
`ifdef RXREQ_LCRD_RETURN_FILTER_EN
      w_push        = w_accept && (bus.rxreqflit.opcode != c_opc_reqlcrdreturn);
`else
      w_push        = w_accept;
`endif

      // A release against an empty POCQ is only an error when no fill
      // lands in the same cycle to pair with it.
      w_rel_err     = bus.pocq_entry_release && !w_dis && (pocq_used_q == '0);

      lcrd_out_d    = lcrd_out_q + c_cnt_w'(lcrdv_q) - c_cnt_w'(w_accept);
      fifo_cnt_d    = fifo_cnt_q + c_cnt_w'(w_push) - c_cnt_w'(w_dis);
      wr_ptr_d      = w_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
      rd_ptr_d      = w_dis  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;

      mem_d         = mem_q;
      if (w_push) begin
         mem_d[wr_ptr_q] = bus.rxreqflit;
      end

      pocq_used_d   = pocq_used_q;
      if (w_dis && !bus.pocq_entry_release) begin
         pocq_used_d = pocq_used_q + c_used_w'(1);
      end else if (!w_dis && bus.pocq_entry_release && (pocq_used_q != '0)) begin
         pocq_used_d = pocq_used_q - c_used_w'(1);
      end

      err_d         = err_q | w_drop_err | w_rel_err;

      // Grant another credit only if, counting that grant, outstanding
      // credits plus buffered flits still fit the FIFO. Using next-state
      // values keeps the budget exact when a flit and a grant overlap.
      w_budget_need = c_sum_w'(lcrd_out_d) + c_sum_w'(fifo_cnt_d) + c_sum_w'(1);
      lcrdv_d       = (w_budget_need <= c_budget);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         lcrd_out_q  <= '0;
         lcrdv_q     <= 1'b0;
         pocq_used_q <= '0;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         lcrd_out_q  <= lcrd_out_d;
         lcrdv_q     <= lcrdv_d;
         pocq_used_q <= pocq_used_d;
         err_q       <= err_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.rxreqlcrdv                 = lcrdv_q;
   assign bus.rxreq_pocq_first_entry_dis = w_dis;
   assign bus.rxreq_pocq_first_entry     = w_fifo_nempty ? mem_q[rd_ptr_q] : '0;
   assign bus.pocq_used                  = pocq_used_q;
   assign bus.rxreq_err                  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rxreq_dispatch.sv
`default_nettype none
//==============================================================================
//  tb_rxreq_dispatch
//------------------------------------------------------------------------------
//  Self-checking bench for rxreq_dispatch: directed vector table, hand-written
//  corner sequences and randomized traffic against a queue-based model.
//
//  Revision: 1.0 - initial release
//==============================================================================
module tb_rxreq_dispatch;
   import rxreq_dispatch_pkg::*;

   localparam int NUM_LCRD   = 4;
   localparam int POCQ_DEPTH = 16;
`ifdef RXREQ_LCRD_RETURN_FILTER_EN
   localparam bit c_filt = 1'b1;
`else
   localparam bit c_filt = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   rxreq_dispatch_if #(.POCQ_DEPTH(POCQ_DEPTH)) bus ();

   rxreq_dispatch #(
      .NUM_LCRD   (NUM_LCRD),
      .POCQ_DEPTH (POCQ_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   reqflit_t mq[$];
   int       m_lcrd, m_used, m_err, m_lcrdv;

   function automatic reqflit_t mk(input logic [11:0] id, input logic [6:0] op);
      reqflit_t r;
      r        = '0;
      r.qos    = 4'h8;
      r.tgtid  = 7'h01;
      r.srcid  = 7'h03;
      r.txnid  = id;
      r.opcode = op;
      r.addr   = {24'h0, 12'hABC, id};
      return r;
   endfunction

   function automatic reqflit_t rnd_flit();
      reqflit_t r;
      r        = '0;
      r.qos    = 4'($urandom);
      r.tgtid  = 7'($urandom);
      r.srcid  = 7'($urandom);
      r.txnid  = 12'($urandom);
      r.opcode = ($urandom % 8 == 0) ? 7'h00 : 7'(1 + $urandom % 100);
      r.addr   = {16'($urandom), 32'($urandom)};
      return r;
   endfunction

   task automatic model_step(input logic fv, input reqflit_t f, input logic rl, input logic rs);
      bit dis, acc;
      if (rs) begin
         mq.delete();
         m_lcrd = 0; m_used = 0; m_err = 0; m_lcrdv = 0;
      end else begin
         dis = (mq.size() > 0) && (m_used < POCQ_DEPTH);
         acc = fv && (m_lcrd > 0);
         if (fv && m_lcrd == 0) m_err = 1;
         m_lcrd = m_lcrd + m_lcrdv - (acc ? 1 : 0);
         if (dis) void'(mq.pop_front());
         if (acc && !(c_filt && f.opcode == 7'h00)) mq.push_back(f);
         if (dis && !rl) m_used++;
         else if (!dis && rl) begin
            if (m_used == 0) m_err = 1;
            else m_used--;
         end
         m_lcrdv = (m_lcrd + mq.size() + 1 <= NUM_LCRD) ? 1 : 0;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      reqflit_t e;
      e = (mq.size() > 0) ? mq[0] : '0;
      chk({tag, "_dis"},   bus.rxreq_pocq_first_entry_dis, ((mq.size() > 0) && (m_used < POCQ_DEPTH)) ? 1 : 0);
      chk({tag, "_entry"}, bus.rxreq_pocq_first_entry, e);
      chk({tag, "_lcrdv"}, bus.rxreqlcrdv, m_lcrdv[0]);
      chk({tag, "_used"},  bus.pocq_used, m_used);
      chk({tag, "_err"},   bus.rxreq_err, m_err[0]);
   endtask

   // Drive inputs for one cycle, clock it, update the model, settle.
   task automatic tick(input logic fv, input reqflit_t f, input logic rl, input logic rs);
      bus.rxreqflitv         = fv;
      bus.rxreqflit          = f;
      bus.pocq_entry_release = rl;
      rst                    = rs;
      @(posedge clk);
      model_step(fv, f, rl, rs);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        fv;
      logic [11:0] id;
      logic        dis;
      logic [11:0] eid;
      logic        lv;
      int          used;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int n, k;
      reqflit_t e;

      bus.rxreqflitv         = 1'b0;
      bus.rxreqflit          = '0;
      bus.pocq_entry_release = 1'b0;

      // credits stream after reset, single flit, then four back-to-back
      tbl[0]  = '{0, 12'h000, 0, 12'h000, 0, 0};
      tbl[1]  = '{0, 12'h000, 0, 12'h000, 1, 0};
      tbl[2]  = '{0, 12'h000, 0, 12'h000, 1, 0};
      tbl[3]  = '{0, 12'h000, 0, 12'h000, 1, 0};
      tbl[4]  = '{0, 12'h000, 0, 12'h000, 1, 0};
      tbl[5]  = '{0, 12'h000, 0, 12'h000, 0, 0};
      tbl[6]  = '{1, 12'h012, 0, 12'h000, 0, 0};
      tbl[7]  = '{0, 12'h000, 1, 12'h012, 0, 0};
      tbl[8]  = '{0, 12'h000, 0, 12'h000, 1, 1};
      tbl[9]  = '{1, 12'h0A0, 0, 12'h000, 0, 1};
      tbl[10] = '{1, 12'h0A1, 1, 12'h0A0, 0, 1};
      tbl[11] = '{1, 12'h0A2, 1, 12'h0A1, 1, 2};
      tbl[12] = '{1, 12'h0A3, 1, 12'h0A2, 1, 3};
      tbl[13] = '{0, 12'h000, 1, 12'h0A3, 1, 4};
      tbl[14] = '{0, 12'h000, 0, 12'h000, 1, 5};
      tbl[15] = '{0, 12'h000, 0, 12'h000, 0, 5};

      for (int i = 0; i < 3; i++) tick(0, '0, 0, 1);

      for (int i = 0; i < 16; i++) begin
         e = tbl[i].dis ? mk(tbl[i].eid, 7'h04) : '0;
         chk($sformatf("tbl%0d_dis", i),   bus.rxreq_pocq_first_entry_dis, tbl[i].dis);
         chk($sformatf("tbl%0d_entry", i), bus.rxreq_pocq_first_entry, e);
         chk($sformatf("tbl%0d_lcrdv", i), bus.rxreqlcrdv, tbl[i].lv);
         chk($sformatf("tbl%0d_used", i),  bus.pocq_used, tbl[i].used);
         chk($sformatf("tbl%0d_err", i),   bus.rxreq_err, 1'b0);
         tick(tbl[i].fv, tbl[i].fv ? mk(tbl[i].id, 7'h04) : '0, 0, 0);
      end

      // ---------------- POCQ full: 11 fills plus 4 backed up ----------------
      n = 0; k = 0;
      while (n < 15 && k < 200) begin
         if (m_lcrd > 0) begin
            tick(1, mk(12'h100 + 12'(n), 7'h04), 0, 0);
            n++;
         end else begin
            tick(0, '0, 0, 0);
         end
         check_model("fill");
         k++;
      end
      chk("fill_sent", n, 15);
      for (int i = 0; i < 8; i++) begin
         tick(0, '0, 0, 0);
         chk("full_dis",   bus.rxreq_pocq_first_entry_dis, 1'b0);
         chk("full_lcrdv", bus.rxreqlcrdv, 1'b0);
      end
      chk("full_used", bus.pocq_used, 16);
      chk("full_head", bus.rxreq_pocq_first_entry.txnid, 12'h10B);

      // flit with no credit outstanding: dropped, error flagged
      tick(1, mk(12'hEEE, 7'h04), 0, 0);
      chk("noc_err",   bus.rxreq_err, 1'b1);
      chk("noc_used",  bus.pocq_used, 16);
      chk("noc_dis",   bus.rxreq_pocq_first_entry_dis, 1'b0);
      chk("noc_head",  bus.rxreq_pocq_first_entry.txnid, 12'h10B);
      check_model("noc");

      // one release -> exactly one dispatch
      tick(0, '0, 1, 0);
      chk("rel_dis",  bus.rxreq_pocq_first_entry_dis, 1'b1);
      chk("rel_id",   bus.rxreq_pocq_first_entry.txnid, 12'h10B);
      chk("rel_used", bus.pocq_used, 15);
      tick(0, '0, 0, 0);
      chk("rel2_dis",   bus.rxreq_pocq_first_entry_dis, 1'b0);
      chk("rel2_used",  bus.pocq_used, 16);
      chk("rel2_lcrdv", bus.rxreqlcrdv, 1'b1);
      check_model("rel2");

      // reset mid-operation discards everything
      tick(0, '0, 0, 1);
      chk("mrst_dis",   bus.rxreq_pocq_first_entry_dis, 1'b0);
      chk("mrst_entry", bus.rxreq_pocq_first_entry, '0);
      chk("mrst_used",  bus.pocq_used, 0);
      chk("mrst_err",   bus.rxreq_err, 1'b0);
      chk("mrst_lcrdv", bus.rxreqlcrdv, 1'b0);

      // release against an empty POCQ
      tick(0, '0, 1, 0);
      chk("erel_err",  bus.rxreq_err, 1'b1);
      chk("erel_used", bus.pocq_used, 0);
      check_model("erel");

      // ---------------- ReqLCrdReturn opcode ----------------
      tick(0, '0, 0, 1);
      for (int i = 0; i < 6; i++) tick(0, '0, 0, 0);
      tick(1, mk(12'h055, 7'h00), 0, 0);
      if (c_filt) begin
         chk("lret_dis",   bus.rxreq_pocq_first_entry_dis, 1'b0);
         chk("lret_lcrdv", bus.rxreqlcrdv, 1'b1);
      end else begin
         chk("lret_dis",   bus.rxreq_pocq_first_entry_dis, 1'b1);
         chk("lret_id",    bus.rxreq_pocq_first_entry.txnid, 12'h055);
      end
      check_model("lret");
      tick(0, '0, 0, 0);
      check_model("lret2");

      // ---------------- randomized traffic ----------------
      tick(0, '0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         logic fv, rl;
         fv = (m_lcrd > 0) ? 1'($urandom % 2) : ($urandom % 300 == 0);
         rl = ((i / 500) % 2 == 1) ? ($urandom % 5 == 0) : ($urandom % 3 != 0);
         tick(fv, rnd_flit(), rl, 0);
         check_model("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
